// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the system-control command sequencer.
package sys_ctrl_pkg;

  // Sequencer states: frame decode, register access, ALU handshake, FIFO push.
  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_GATE,
    ALU_RUN,
    ALU_WAIT,
    TX_RD,
    TX_LO,
    TX_HI
  } state_e;

  // Command bytes that open a frame.
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // True in the states that are waiting for the next byte of a frame.
  function automatic logic is_frame_wait(state_e s);
    return s inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN};
  endfunction

endpackage

// File: rtl/sys_ctrl_fsm_if.sv
// Bundle of the sequencer's data-path connections: RX byte stream, register
// file, ALU and TX FIFO. The master side is the sequencer itself.
interface sys_ctrl_fsm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   rx_p_data;
  logic                    rx_d_vld;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_data_vld;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_vld;
  logic                    fifo_full;

  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic                    rf_wr_en;
  logic                    rf_rd_en;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic [FUN_WIDTH-1:0]    alu_fun;
  logic                    alu_en;
  logic                    clk_gate_en;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    fifo_wr_inc;

  modport master (
    input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld,
           alu_out, alu_out_vld, fifo_full,
    output rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_fun, alu_en,
           clk_gate_en, fifo_wr_data, fifo_wr_inc
  );

  modport slave (
    output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld,
           alu_out, alu_out_vld, fifo_full,
    input  rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_fun, alu_en,
           clk_gate_en, fifo_wr_data, fifo_wr_inc
  );
endinterface

// File: rtl/sys_ctrl_tx_push.sv
// TX FIFO push sequencer. While req is held it pushes the presented byte on
// the first cycle the FIFO is not full and signals done in that same cycle,
// so the caller can step to its next byte (one byte for a read response, two
// for an ALU result). The push strobe and data are registered.
module sys_ctrl_tx_push #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  REF_CLK,
  input  logic                  RST,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  fifo_full,
  output logic                  done,
  output logic                  fifo_wr_inc,
  output logic [DATA_WIDTH-1:0] fifo_wr_data
);

  // A byte is accepted only in a cycle where the FIFO has room.
  assign done = req & ~fifo_full;

  // Register the push strobe and hold the last pushed byte.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      fifo_wr_inc  <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_inc <= done;
      if (done) fifo_wr_data <= data;
    end
  end

endmodule

// File: rtl/sys_ctrl_fsm.sv
// Command sequencer: decodes framed RX bytes (AA write, BB read, CC operand
// load + ALU, DD ALU on stored operands), drives the register file and the
// gated ALU, and pushes responses into the TX FIFO. All outputs registered.
// Optional inter-byte timeout: define SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_fsm
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           REF_CLK,
  input logic           RST,
  sys_ctrl_fsm_if.master bus
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;

  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic                    clk_gate_en_q, clk_gate_en_d;

  logic                    tx_req;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_done;
  logic                    fifo_wr_inc;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;

  logic                    rx_vld;
  logic [DATA_WIDTH-1:0]   rx_byte;

  assign rx_vld  = bus.rx_d_vld;
  assign rx_byte = bus.rx_p_data;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Silence in a byte-wait state long enough abandons the frame.
  assign tmo_hit = is_frame_wait(state_q) && !rx_vld &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte counter: cleared by any byte or outside the wait states.
  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST)                                          tmo_cnt_q <= '0;
    else if (rx_vld || !is_frame_wait(state_q) || tmo_hit) tmo_cnt_q <= '0;
    else                                               tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`endif

  // Next-state and next-output decode; strobes default low every cycle.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_data_d    = rd_data_q;
    result_d     = result_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_fun_d    = alu_fun_q;
    tx_req       = 1'b0;
    tx_data      = rd_data_q;

    case (state_q)
      IDLE: if (rx_vld) begin
        if      (rx_byte == DATA_WIDTH'(CMD_RF_WR))   state_d = WR_ADDR;
        else if (rx_byte == DATA_WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
        else if (rx_byte == DATA_WIDTH'(CMD_ALU_OP))  state_d = OPA;
        else if (rx_byte == DATA_WIDTH'(CMD_ALU_NOP)) state_d = FUN;
      end
      WR_ADDR: if (rx_vld) begin
        addr_d  = rx_byte[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_vld) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = addr_q;
        rf_wr_data_d = rx_byte;
        state_d      = IDLE;
      end
      RD_ADDR: if (rx_vld) begin
        rf_rd_en_d = 1'b1;
        rf_addr_d  = rx_byte[ADDR_WIDTH-1:0];
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (bus.rf_rd_data_vld) begin
        rd_data_d = bus.rf_rd_data;
        state_d   = TX_RD;
      end
      OPA: if (rx_vld) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
        rf_wr_data_d = rx_byte;
        state_d      = OPB;
      end
      OPB: if (rx_vld) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
        rf_wr_data_d = rx_byte;
        state_d      = FUN;
      end
      FUN: if (rx_vld) begin
        alu_fun_d = rx_byte[FUN_WIDTH-1:0];
        state_d   = ALU_GATE;
      end
      ALU_GATE: state_d = ALU_RUN;
      ALU_RUN:  state_d = ALU_WAIT;
      ALU_WAIT: if (bus.alu_out_vld) begin
        result_d = bus.alu_out;
        state_d  = TX_LO;
      end
      TX_RD: begin
        tx_req  = 1'b1;
        tx_data = rd_data_q;
        if (tx_done) state_d = IDLE;
      end
      TX_LO: begin
        tx_req  = 1'b1;
        tx_data = result_q[DATA_WIDTH-1:0];
        if (tx_done) state_d = TX_HI;
      end
      TX_HI: begin
        tx_req  = 1'b1;
        tx_data = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    // tmo_hit implies no byte this cycle, so no strobe was raised above.
    if (tmo_hit) state_d = IDLE;
`endif

    // Gate opens one cycle ahead of the single alu_en pulse and stays open
    // until the result has been captured.
    clk_gate_en_d = state_d inside {ALU_GATE, ALU_RUN, ALU_WAIT};
    alu_en_d      = (state_d == ALU_RUN);
  end

  // State, frame context and registered outputs.
  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rd_data_q     <= '0;
      result_q      <= '0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      alu_fun_q     <= '0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_data_q     <= rd_data_d;
      result_q      <= result_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      alu_fun_q     <= alu_fun_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
    end
  end

  sys_ctrl_tx_push #(.DATA_WIDTH(DATA_WIDTH)) u_tx_push (
    .REF_CLK      (REF_CLK),
    .RST          (RST),
    .req          (tx_req),
    .data         (tx_data),
    .fifo_full    (bus.fifo_full),
    .done         (tx_done),
    .fifo_wr_inc  (fifo_wr_inc),
    .fifo_wr_data (fifo_wr_data)
  );

  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_rd_en     = rf_rd_en_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.alu_fun      = alu_fun_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.clk_gate_en  = clk_gate_en_q;
  assign bus.fifo_wr_inc  = fifo_wr_inc;
  assign bus.fifo_wr_data = fifo_wr_data;

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Testbench for sys_ctrl_fsm: directed frames, a frame-level expectation
// model (queues of expected writes, reads, ALU ops and FIFO bytes), and
// small register-file / ALU responders.
`timescale 1ns/1ps
module tb_sys_ctrl_fsm;
  import sys_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int TMO = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_fsm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

  sys_ctrl_fsm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .REF_CLK (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] model_rf [16];
  logic [7:0] frame [$];
  wr_t        exp_wr [$];
  logic [3:0] exp_rd [$];
  logic [3:0] exp_fun [$];
  logic [7:0] exp_push [$];
  logic [7:0] pushed [$];
  int         wr_seen  = 0;
  int         alu_seen = 0;
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  task automatic expect_alu(input logic [3:0] f);
    logic [15:0] r;
    r = alu_ref(model_rf[0], model_rf[1], f);
    exp_fun.push_back(f);
    exp_push.push_back(r[7:0]);
    exp_push.push_back(r[15:8]);
  endtask

  // Feed one accepted RX byte into the model and queue what it must cause.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] cmd, b1, b2;
    frame.push_back(b);
    cmd = frame[0];
    case (cmd)
      8'hAA: if (frame.size() == 3) begin
        b1 = frame[1]; b2 = frame[2];
        exp_wr.push_back('{addr: b1[3:0], data: b2});
        model_rf[b1[3:0]] = b2;
        frame.delete();
      end
      8'hBB: if (frame.size() == 2) begin
        b1 = frame[1];
        exp_rd.push_back(b1[3:0]);
        exp_push.push_back(model_rf[b1[3:0]]);
        frame.delete();
      end
      8'hCC: begin
        b1 = frame[frame.size()-1];
        if (frame.size() == 2) begin
          exp_wr.push_back('{addr: 4'd0, data: b1});
          model_rf[0] = b1;
        end else if (frame.size() == 3) begin
          exp_wr.push_back('{addr: 4'd1, data: b1});
          model_rf[1] = b1;
        end else if (frame.size() == 4) begin
          expect_alu(b1[3:0]);
          frame.delete();
        end
      end
      8'hDD: if (frame.size() == 2) begin
        b1 = frame[1];
        expect_alu(b1[3:0]);
        frame.delete();
      end
      default: frame.delete();
    endcase
  endtask

  function automatic int pending();
    return exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_push.size();
  endfunction

  // ---------------- responders ----------------
  // Register file: answer a read two cycles after the strobe.
  initial begin : rf_responder
    logic [3:0] a;
    bus.rf_rd_data     = '0;
    bus.rf_rd_data_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rf_rd_en) begin
        a = bus.rf_addr;
        @(posedge clk); @(posedge clk); #1;
        bus.rf_rd_data     = model_rf[a];
        bus.rf_rd_data_vld = 1'b1;
        @(posedge clk); #1;
        bus.rf_rd_data_vld = 1'b0;
      end
    end
  end

  // ALU: answer two cycles after alu_en using the stored operands.
  initial begin : alu_responder
    logic [3:0] f;
    bus.alu_out     = '0;
    bus.alu_out_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_en) begin
        f = bus.alu_fun;
        @(posedge clk); @(posedge clk); #1;
        bus.alu_out     = alu_ref(model_rf[0], model_rf[1], f);
        bus.alu_out_vld = 1'b1;
        @(posedge clk); #1;
        bus.alu_out_vld = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  logic full_at_edge = 1'b0;
  always @(posedge clk) full_at_edge <= bus.fifo_full;

  initial begin : compare
    logic prev_gate, prev2_gate, prev_alu_en, prev_alu_vld;
    wr_t  ew;
    logic [3:0] ea;
    logic [7:0] eb;
    prev_gate = 0; prev2_gate = 0; prev_alu_en = 0; prev_alu_vld = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.rf_wr_en) begin
          wr_seen++;
          last_wr_addr = bus.rf_addr;
          last_wr_data = bus.rf_wr_data;
          check("rf_wr_expected", 32'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            check("rf_wr_addr", bus.rf_addr, ew.addr);
            check("rf_wr_data", bus.rf_wr_data, ew.data);
          end
        end
        if (bus.rf_rd_en) begin
          check("rf_rd_expected", 32'(exp_rd.size() > 0), 1);
          if (exp_rd.size() > 0) begin
            ea = exp_rd.pop_front();
            check("rf_rd_addr", bus.rf_addr, ea);
          end
        end
        if (bus.alu_en) begin
          alu_seen++;
          check("alu_en_expected", 32'(exp_fun.size() > 0), 1);
          if (exp_fun.size() > 0) begin
            ea = exp_fun.pop_front();
            check("alu_fun", bus.alu_fun, ea);
          end
          check("gate_lead", {prev2_gate, prev_gate, bus.clk_gate_en}, 3'b011);
          check("alu_en_single", prev_alu_en, 0);
        end
        if (bus.alu_out_vld) check("gate_in_wait", bus.clk_gate_en, 1);
        if (prev_alu_vld)    check("gate_drop", bus.clk_gate_en, 0);
        if (bus.fifo_wr_inc) begin
          pushed.push_back(bus.fifo_wr_data);
          check("push_not_full", full_at_edge, 0);
          check("push_expected", 32'(exp_push.size() > 0), 1);
          if (exp_push.size() > 0) begin
            eb = exp_push.pop_front();
            check("push_data", bus.fifo_wr_data, eb);
          end
        end
      end
      prev2_gate   = prev_gate;
      prev_gate    = bus.clk_gate_en;
      prev_alu_en  = bus.alu_en;
      prev_alu_vld = bus.alu_out_vld;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    bus.rx_d_vld  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, pending(), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.rf_addr, bus.rf_wr_en, bus.rf_rd_en, bus.rf_wr_data, bus.alu_fun,
                 bus.alu_en, bus.clk_gate_en, bus.fifo_wr_data, bus.fifo_wr_inc}, 0);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int w0, a0;
    bus.rx_p_data = '0;
    bus.rx_d_vld  = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    check("reset_state", dut.state_q, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;

    // AA,05,3C : single register write
    w0 = wr_seen; pushed.delete();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    drain("wr", 50);
    check("wr_count", wr_seen - w0, 1);
    check("wr_addr_lit", last_wr_addr, 4'h5);
    check("wr_data_lit", last_wr_data, 8'h3C);
    check("wr_no_push", pushed.size(), 0);
    check("wr_idle", dut.state_q, IDLE);

    // BB,05 : one response byte 0x3C
    pushed.delete();
    send_byte(8'hBB); send_byte(8'h05);
    drain("rd", 50);
    check("rd_push_count", pushed.size(), 1);
    if (pushed.size() > 0) check("rd_push_lit", pushed[0], 8'h3C);

    // CC,12,34,00 : add -> 0x0046
    w0 = wr_seen; a0 = alu_seen; pushed.delete();
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    drain("alu_add", 60);
    check("add_wr_count", wr_seen - w0, 2);
    check("add_alu_count", alu_seen - a0, 1);
    check("add_push_count", pushed.size(), 2);
    if (pushed.size() == 2) begin
      check("add_lo_lit", pushed[0], 8'h46);
      check("add_hi_lit", pushed[1], 8'h00);
    end

    // DD,02 with FIFO full: 0x12*0x34 = 0x03A8, held until not full
    a0 = alu_seen; pushed.delete();
    @(posedge clk); #1 bus.fifo_full = 1'b1;
    send_byte(8'hDD); send_byte(8'h02);
    repeat (10) @(posedge clk);
    check("full_no_push", pushed.size(), 0);
    check("full_hold_state", dut.state_q, TX_LO);
    #1 bus.fifo_full = 1'b0;
    drain("alu_full", 60);
    check("mul_alu_count", alu_seen - a0, 1);
    check("mul_push_count", pushed.size(), 2);
    if (pushed.size() == 2) begin
      check("mul_lo_lit", pushed[0], 8'hA8);
      check("mul_hi_lit", pushed[1], 8'h03);
    end

    // Stray 0x55 in IDLE, then AA,03,FF
    w0 = wr_seen;
    send_byte(8'h55);
    check("stray_idle", dut.state_q, IDLE);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'hFF);
    drain("stray", 50);
    check("stray_wr_count", wr_seen - w0, 1);
    check("stray_wr_addr", last_wr_addr, 4'h3);
    check("stray_wr_data", last_wr_data, 8'hFF);

    // Reset while in OPB of a CC frame; partial frame discarded
    send_byte(8'hCC); send_byte(8'h77);
    drain("pre_reset", 50);
    check("pre_reset_state", dut.state_q, OPB);
    @(posedge clk); #1 rst_n = 1'b0;
    frame.delete();
    @(negedge clk);
    check_outputs_zero("midframe_reset_outputs");
    check("midframe_reset_state", dut.state_q, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;
    w0 = wr_seen; pushed.delete();
    send_byte(8'h88);
    send_byte(8'hBB); send_byte(8'h00);
    drain("post_reset", 50);
    check("post_reset_no_wr", wr_seen - w0, 0);
    check("post_reset_push_count", pushed.size(), 1);
    if (pushed.size() > 0) check("post_reset_push_lit", pushed[0], 8'h77);

`ifdef SYS_CTRL_TIMEOUT_EN
    // AA then silence: frame abandoned, later bytes are not its address/data
    w0 = wr_seen;
    send_byte(8'hAA);
    repeat (TMO + 5) @(posedge clk);
    check("timeout_idle", dut.state_q, IDLE);
    frame.delete();
    send_byte(8'h05); send_byte(8'h3C);
    drain("timeout", 50);
    check("timeout_no_wr", wr_seen - w0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_fsm.md
Name: sys_ctrl_fsm

Overview:
- Command sequencer in the REF_CLK domain, between the synchronized UART RX byte stream and the register file, the gated ALU and the TX FIFO.
- Decodes framed commands byte by byte, then issues register-file writes and reads and ALU operations.
- Drives the ALU clock-gate enable, and pushes responses (read data or a 16-bit ALU result) into the TX FIFO, honouring the FIFO full flag.

Parameters:
- DATA_WIDTH, 8, width of RX byte, register-file data and FIFO data.
- ADDR_WIDTH, 4, register-file address width.
- FUN_WIDTH, 4, ALU function code width.
- OPA_ADDR, 0, register-file address receiving operand A.
- OPB_ADDR, 1, register-file address receiving operand B.
- TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with SYS_CTRL_TIMEOUT_EN.

Ports:
- REF_CLK in 1: system clock.
- RST in 1: asynchronous reset, active-low.
- rx_p_data in DATA_WIDTH: synchronized RX byte.
- rx_d_vld in 1: one-cycle pulse per byte.
- rf_rd_data in DATA_WIDTH: register-file read data.
- rf_rd_data_vld in 1: read data valid pulse.
- alu_out in 2*DATA_WIDTH: ALU result.
- alu_out_vld in 1: ALU result valid pulse.
- fifo_full in 1: TX FIFO full.
- rf_addr out ADDR_WIDTH: register-file address.
- rf_wr_en out 1: register-file write strobe.
- rf_rd_en out 1: register-file read strobe.
- rf_wr_data out DATA_WIDTH: register-file write data.
- alu_fun out FUN_WIDTH: ALU function code.
- alu_en out 1: ALU operation enable.
- clk_gate_en out 1: ALU clock-gate enable.
- fifo_wr_data out DATA_WIDTH: TX FIFO write data.
- fifo_wr_inc out 1: TX FIFO push strobe.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.
- Frame formats (first byte is the command):
  - 0xAA: addr, data → register write.
  - 0xBB: addr → register read, one response byte.
  - 0xCC: A, B, fun → operand write, then ALU.
  - 0xDD: fun → ALU using operands already stored.
- Bytes are consumed only in cycles where rx_d_vld=1; the state holds otherwise.
- Only the low ADDR_WIDTH bits of an address byte and the low FUN_WIDTH bits of a fun byte are used.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_GATE, ALU_RUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- IDLE: on vld, 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OPA, 0xDD→FUN. Any other byte is discarded and the state stays IDLE.
- WR_ADDR: latch addr → WR_DATA.
- WR_DATA: on vld, the next cycle drives rf_wr_en=1 for exactly 1 cycle with rf_addr/rf_wr_data; → IDLE.
- RD_ADDR: on vld, the next cycle drives rf_rd_en=1 for 1 cycle; → RD_WAIT.
- RD_WAIT: on rf_rd_data_vld, latch data → TX_RD.
- OPA / OPB: on vld, write the byte to OPA_ADDR / OPB_ADDR (1-cycle rf_wr_en) → OPB / FUN.
- FUN: on vld, latch fun → ALU_GATE.
- ALU_GATE: clk_gate_en=1 for one cycle, alu_en=0 → ALU_RUN.
- ALU_RUN: clk_gate_en=1, alu_en=1 for exactly 1 cycle, alu_fun valid → ALU_WAIT.
- ALU_WAIT: clk_gate_en=1; on alu_out_vld, latch the 16-bit result → TX_LO. clk_gate_en drops in the cycle after the result is latched.
- TX_RD / TX_LO / TX_HI: fifo_wr_inc=1 for 1 cycle only when fifo_full=0, with fifo_wr_data driven. If full, hold the state and hold fifo_wr_inc=0.
  - TX_LO sends result[7:0], then → TX_HI, which sends result[15:8].
  - TX_RD and TX_HI return to IDLE after their push.
- rx_d_vld arriving in the RD_WAIT, ALU_*, or TX_* states is ignored; that byte is lost.
- Reset mid-frame: immediate return to IDLE, all strobes low, the partial frame is discarded.
- A command byte is never also interpreted as data within the same cycle.

Optional Feature:
- SYS_CTRL_TIMEOUT_EN defined:
  - A counter clears on every rx_d_vld and counts while in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB or FUN.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no side effects.
  - Operand bytes already written stay written.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - the state enum;
  - command constants CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD.
- Natural sub-module: sys_ctrl_tx_push, the FIFO push sequencer. It takes 1 or 2 bytes, applies the fifo_full stall, and returns a done pulse.

Test Plan:
- Frame AA,05,3C → single rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C; FSM back in IDLE; no FIFO push.
- Frame BB,05 with rf_rd_data=0x3C returned 2 cycles after rf_rd_en → exactly one push of 0x3C.
- Frame CC,12,34,00 (add) with alu_out=0x0046 → writes 0x12@0 and 0x34@1; clk_gate_en rises 1 cycle before the alu_en pulse; pushes 0x46 then 0x00.
- Frame DD,02 with fifo_full=1 for 10 cycles → no push while full; 0xLO pushed on the first not-full cycle, then 0xHI; alu_en pulses exactly once.
- Byte 0x55 in IDLE, then AA,03,FF → 0x55 ignored; 0xFF written to address 3.
- RST low during OPB of a CC frame → all outputs 0, FSM in IDLE. With SYS_CTRL_TIMEOUT_EN, AA then silence for TIMEOUT_CYCLES → FSM in IDLE, no rf_wr_en.
